// File: rtl/mips_io_bus_if.sv
// Data-side bus between the single-cycle MIPS core and its memory/IO system.
// The core drives the strobe, address and store data; readdata comes back in the same cycle.
interface mips_io_bus_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output memwrite, output addr, output writedata, input readdata);
    modport slave  (input memwrite, input addr, input writedata, output readdata);
endinterface

// File: rtl/mips_io_bus.sv
// Word-addressed data RAM plus memory-mapped LEDs, synchronized switches, a cycle counter
// and a down-counting timer with a sticky expiry flag. Reads are combinational; writes commit at the edge.
module mips_io_bus #(
    parameter int DMEM_WORDS = 64,
    parameter int SW_WIDTH   = 16,
    parameter int LED_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_io_bus_if.slave         bus,
    input  logic [SW_WIDTH-1:0]  sw,
    output logic [LED_WIDTH-1:0] led,
    output logic                 timer_irq
);
    localparam int AW = $clog2(DMEM_WORDS);

    localparam logic [5:0] OFF_LED   = 6'd0;
    localparam logic [5:0] OFF_SW    = 6'd1;
    localparam logic [5:0] OFF_CYCLE = 6'd2;
    localparam logic [5:0] OFF_LOAD  = 6'd3;
    localparam logic [5:0] OFF_COUNT = 6'd4;
    localparam logic [5:0] OFF_CTRL  = 6'd5;
    localparam logic [5:0] OFF_STAT  = 6'd6;

    logic [31:0]          dmem [DMEM_WORDS];
    logic [AW-1:0]        ram_idx;
    logic                 is_io;
    logic [5:0]           io_off;

    logic [SW_WIDTH-1:0]  sw_meta;
    logic [SW_WIDTH-1:0]  sw_sync;
    logic [31:0]          cycle_cnt;
    logic [31:0]          tmr_load;
    logic [31:0]          tmr_count;
    logic                 tmr_en;
    logic                 tmr_auto;
    logic                 tmr_irq_en;
    logic                 tmr_expired;

    logic                 io_we;
    logic                 wr_led;
    logic                 wr_load;
    logic                 wr_ctrl;
    logic                 wr_stat_clr;
    logic                 tmr_fire;

    assign ram_idx = bus.addr[AW+1:2];
    assign is_io   = bus.addr[31];
    assign io_off  = bus.addr[7:2];

    assign io_we       = bus.memwrite && is_io;
    assign wr_led      = io_we && (io_off == OFF_LED);
    assign wr_load     = io_we && (io_off == OFF_LOAD);
    assign wr_ctrl     = io_we && (io_off == OFF_CTRL);
    assign wr_stat_clr = io_we && (io_off == OFF_STAT) && bus.writedata[0];

    // A count of 1 is the last tick; a count of 0 is idle even when enabled.
    assign tmr_fire = tmr_en && (tmr_count == 32'd1);

    assign timer_irq = tmr_expired && tmr_irq_en;

    // RAM is not reset so program data survives a peripheral reset.
    always_ff @(posedge clk) begin
        if (bus.memwrite && !is_io) begin
            dmem[ram_idx] <= bus.writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta     <= '0;
            sw_sync     <= '0;
            cycle_cnt   <= '0;
            led         <= '0;
            tmr_load    <= '0;
            tmr_count   <= '0;
            tmr_en      <= 1'b0;
            tmr_auto    <= 1'b0;
            tmr_irq_en  <= 1'b0;
            tmr_expired <= 1'b0;
        end else begin
            sw_meta   <= sw;
            sw_sync   <= sw_meta;
            cycle_cnt <= cycle_cnt + 32'd1;

            if (wr_led) begin
                led <= bus.writedata[LED_WIDTH-1:0];
            end
            if (wr_ctrl) begin
                {tmr_irq_en, tmr_auto, tmr_en} <= bus.writedata[2:0];
            end
            if (wr_load) begin
                tmr_load <= bus.writedata;
            end

            // A software load always wins over the timer's own update.
            if (wr_load) begin
                tmr_count <= bus.writedata;
            end else if (tmr_fire) begin
                tmr_count <= tmr_auto ? tmr_load : 32'd0;
            end else if (tmr_en && (tmr_count != 32'd0)) begin
                tmr_count <= tmr_count - 32'd1;
            end

            // An expiry that coincides with a clear must not be lost.
            if (tmr_fire) begin
                tmr_expired <= 1'b1;
            end else if (wr_stat_clr) begin
                tmr_expired <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.readdata = 32'd0;
        if (!is_io) begin
            bus.readdata = dmem[ram_idx];
        end else begin
            case (io_off)
                OFF_LED:   bus.readdata = 32'(led);
                OFF_SW:    bus.readdata = 32'(sw_sync);
                OFF_CYCLE: bus.readdata = cycle_cnt;
                OFF_LOAD:  bus.readdata = tmr_load;
                OFF_COUNT: bus.readdata = tmr_count;
                OFF_CTRL:  bus.readdata = {29'd0, tmr_irq_en, tmr_auto, tmr_en};
                OFF_STAT:  bus.readdata = {31'd0, tmr_expired};
                default:   bus.readdata = 32'd0;
            endcase
        end
    end
endmodule
